// File: rtl/p1_sprite_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : p1_sprite_fetch_if                                        |
// | Desc     : Sprite ROM bus: address/frame select out, pixel data back |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface p1_sprite_fetch_if;
  logic [13:0] rom_addr;
  logic [1:0]  frame_sel;
  logic [11:0] rom_data;

  modport master (output rom_addr, output frame_sel, input  rom_data);
  modport slave  (input  rom_addr, input  frame_sel, output rom_data);
endinterface
`default_nettype wire

// File: rtl/p1_sprite_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : p1_sprite_fetch                                           |
// | Desc     : 3-stage sprite pixel fetch with walk animation frames.    |
// |            Define SPRITE_MIRROR_EN for horizontal mirroring.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module p1_sprite_fetch #(
  parameter int          SPRITE_W       = 128,
  parameter int          SPRITE_H       = 128,
  parameter int          NUM_FRAMES     = 3,
  parameter int          TICKS_PER_STEP = 8,
  parameter logic [11:0] TRANSPARENT    = 12'hF0F
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic [9:0]   pix_x,
  input  wire logic [9:0]   pix_y,
  input  wire logic         pix_valid,
  input  wire logic         frame_tick,
  input  wire logic [9:0]   sprite_x,
  input  wire logic [9:0]   sprite_y,
  input  wire logic         walking,
  input  wire logic         facing_left,
  p1_sprite_fetch_if.master rom,
  output logic [11:0]       pixel_out,
  output logic              pixel_hit,
  output logic              out_valid
);

  localparam logic [7:0] c_TICK_LAST = 8'(TICKS_PER_STEP - 1);
  localparam logic [1:0] c_FS_LAST   = 2'(NUM_FRAMES - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WALK = 1'b1} state_t;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_tick, w_tick_nx, w_tick_step;
  logic [1:0]  r_fs, w_fs_nx, w_fs_step;
  logic [9:0]  r_sx, r_sy;
  logic [10:0] w_px, w_py, w_sx, w_sy;
  logic        w_in_box;
  logic [6:0]  w_dy, w_col_raw, w_col;
  logic [13:0] r_rom_addr;
  logic        r_in1, r_v1, r_in2, r_v2;
  logic        w_opaque;

  // Position only moves on vertical blank so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (frame_tick) begin
      r_sx <= sprite_x;
      r_sy <= sprite_y;
    end
  end

  assign w_px = {1'b0, pix_x};
  assign w_py = {1'b0, pix_y};
  assign w_sx = {1'b0, r_sx};
  assign w_sy = {1'b0, r_sy};
  assign w_in_box = pix_valid
                  && (w_px >= w_sx) && (w_px < w_sx + 11'(SPRITE_W))
                  && (w_py >= w_sy) && (w_py < w_sy + 11'(SPRITE_H));

  assign w_dy      = pix_y[6:0] - r_sy[6:0];
  assign w_col_raw = pix_x[6:0] - r_sx[6:0];

`ifdef SPRITE_MIRROR_EN
  logic r_face;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_face <= 1'b0;
    else if (frame_tick) r_face <= facing_left;
  end
  assign w_col = r_face ? (7'(SPRITE_W - 1) - w_col_raw) : w_col_raw;
`else
  logic w_unused_facing;
  assign w_unused_facing = facing_left;
  assign w_col = w_col_raw;
`endif

  // Stage 1 address, stage 2 waits on ROM, stage 3 colour-keys the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_in1      <= 1'b0;
      r_v1       <= 1'b0;
      r_in2      <= 1'b0;
      r_v2       <= 1'b0;
      pixel_out  <= '0;
      pixel_hit  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      r_rom_addr <= w_in_box ? {w_dy, w_col} : 14'd0;
      r_in1      <= w_in_box;
      r_v1       <= pix_valid;
      r_in2      <= r_in1;
      r_v2       <= r_v1;
      pixel_hit  <= w_opaque;
      pixel_out  <= w_opaque ? rom.rom_data : 12'h000;
      out_valid  <= r_v2;
    end
  end

  assign w_opaque      = r_in2 && (rom.rom_data != TRANSPARENT);
  assign rom.rom_addr  = r_rom_addr;
  assign rom.frame_sel = r_fs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_fs    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tick  <= w_tick_nx;
      r_fs    <= w_fs_nx;
    end
  end

  // IDLE holds counter and frame at zero, so the entering tick counts as step one
  always_comb begin
    w_state_nx  = r_state;
    w_tick_nx   = r_tick;
    w_fs_nx     = r_fs;
    w_tick_step = r_tick + 8'd1;
    w_fs_step   = r_fs;
    if (r_tick == c_TICK_LAST) begin
      w_tick_step = '0;
      w_fs_step   = (r_fs == c_FS_LAST) ? 2'd0 : r_fs + 2'd1;
    end
    if (frame_tick) begin
      case (r_state)
        S_IDLE: begin
          if (walking) begin
            w_state_nx = S_WALK;
            w_tick_nx  = w_tick_step;
            w_fs_nx    = w_fs_step;
          end
        end
        S_WALK: begin
          if (walking) begin
            w_tick_nx = w_tick_step;
            w_fs_nx   = w_fs_step;
          end else begin
            w_state_nx = S_IDLE;
            w_tick_nx  = '0;
            w_fs_nx    = '0;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_tick_nx  = '0;
          w_fs_nx    = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_p1_sprite_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_p1_sprite_fetch                                        |
// | Desc     : Directed + random bench with a 3-cycle reference model.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_p1_sprite_fetch;

  typedef struct {
    logic [13:0] addr;
    logic [1:0]  fs;
    logic [11:0] pix;
    logic        hit;
    logic        v;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0, sprite_x = '0, sprite_y = '0;
  logic        pix_valid = 1'b0, frame_tick = 1'b0, walking = 1'b0, facing_left = 1'b0;
  logic [11:0] pixel_out;
  logic        pixel_hit, out_valid;

  logic [11:0] rom_mem [0:16383];
  rec_t        hist[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          m_sx = 0, m_sy = 0, m_wt = 0;
  bit          m_face = 1'b0;
  int          s_x = 0, s_y = 0;
  bit          s_walk = 1'b0, s_face = 1'b0;

  p1_sprite_fetch_if rom_if ();

  p1_sprite_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .frame_tick  (frame_tick),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .walking     (walking),
    .facing_left (facing_left),
    .rom         (rom_if.master),
    .pixel_out   (pixel_out),
    .pixel_hit   (pixel_hit),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle later
  always @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rec_t z;
    z = '{addr: '0, fs: '0, pix: '0, hit: 1'b0, v: 1'b0};
    hist.delete();
    repeat (3) hist.push_front(z);
    m_sx = 0; m_sy = 0; m_wt = 0; m_face = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".rom_addr"},  32'(rom_if.rom_addr),  32'd0);
    chk({tag, ".frame_sel"}, 32'(rom_if.frame_sel), 32'd0);
    chk({tag, ".pixel_out"}, 32'(pixel_out),        32'd0);
    chk({tag, ".pixel_hit"}, 32'(pixel_hit),        32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid),        32'd0);
  endtask

  // One clock: apply inputs, predict, then check stage-1 and stage-3 outputs
  task automatic drive(input int px, input int py, input bit pv, input bit tick);
    rec_t r;
    bit   inb;
    int   col, a;
    logic [11:0] d;
    pix_x = 10'(px); pix_y = 10'(py); pix_valid = pv; frame_tick = tick;
    sprite_x = 10'(s_x); sprite_y = 10'(s_y); walking = s_walk; facing_left = s_face;
    inb = pv && px >= m_sx && px < m_sx + 128 && py >= m_sy && py < m_sy + 128;
    col = px - m_sx;
`ifdef SPRITE_MIRROR_EN
    if (m_face) col = 127 - col;
`endif
    a = inb ? (py - m_sy) * 128 + col : 0;
    d = rom_mem[a];
    r.addr = 14'(a);
    r.hit  = inb && (d != 12'hF0F);
    r.pix  = r.hit ? d : 12'h000;
    r.v    = pv;
    if (tick) begin
      m_sx = s_x; m_sy = s_y; m_face = s_face;
      m_wt = s_walk ? m_wt + 1 : 0;
    end
    r.fs = 2'((m_wt / 8) % 3);
    hist.push_front(r);
    if (hist.size() > 3) void'(hist.pop_back());
    @(posedge clk); #1;
    chk("rom_addr",  32'(rom_if.rom_addr),  32'(hist[0].addr));
    chk("frame_sel", 32'(rom_if.frame_sel), 32'(hist[0].fs));
    chk("pixel_out", 32'(pixel_out),        32'(hist[2].pix));
    chk("pixel_hit", 32'(pixel_hit),        32'(hist[2].hit));
    chk("out_valid", 32'(out_valid),        32'(hist[2].v));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++)
      rom_mem[i] = ($urandom_range(0, 7) == 0) ? 12'hF0F : 12'($urandom);
    rom_mem[0]     = 12'hABC;
    rom_mem[16383] = 12'h123;
    rom_mem[1290]  = 12'hF0F;
    rom_mem[2580]  = 12'h5A5;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Latch sx=100, sy=50 and walk the corners of the box
    s_x = 100; s_y = 50; s_face = 1'b0;
    drive(0, 0, 1'b0, 1'b1);
    idle(2);
    drive(100, 50, 1'b1, 1'b0);
    drive(227, 177, 1'b1, 1'b0);
    drive(228, 177, 1'b1, 1'b0);
    drive(110, 60, 1'b1, 1'b0);
    drive(99, 50, 1'b1, 1'b0);
    drive(100, 178, 1'b1, 1'b0);
    drive(150, 100, 1'b0, 1'b0);
    idle(3);

    // Facing left: mirrored column only when the option is built in
    s_face = 1'b1;
    drive(0, 0, 1'b0, 1'b1);
    drive(100, 50, 1'b1, 1'b0);
    drive(227, 50, 1'b1, 1'b0);
    s_face = 1'b0;
    drive(0, 0, 1'b0, 1'b1);
    idle(3);

    // Walk animation: 24 ticks, then stop
    s_walk = 1'b1;
    for (int t = 0; t < 24; t++) begin
      drive(0, 0, 1'b0, 1'b1);
      idle(2);
    end
    s_walk = 1'b0;
    drive(0, 0, 1'b0, 1'b1);
    idle(2);
    // Stop mid-step from frame 1
    s_walk = 1'b1;
    for (int t = 0; t < 10; t++) drive(120, 60, 1'b1, 1'b1);
    s_walk = 1'b0;
    drive(120, 60, 1'b1, 1'b1);
    idle(3);

    // Right-edge sprite: no 10-bit wrap of the box
    s_x = 1000; s_y = 0;
    drive(0, 0, 1'b0, 1'b1);
    drive(1020, 20, 1'b1, 1'b0);
    drive(1023, 127, 1'b1, 1'b0);
    drive(3, 5, 1'b1, 1'b0);
    drive(999, 5, 1'b1, 1'b0);
    drive(1020, 128, 1'b1, 1'b0);
    idle(3);

    // Randomized traffic with ticks landing during active video
    for (int i = 0; i < 600; i++) begin
      int px, py;
      bit tk;
      tk = ($urandom_range(0, 15) == 0);
      if (tk) begin
        s_x = $urandom_range(0, 1023);
        s_y = $urandom_range(0, 1023);
        s_walk = ($urandom_range(0, 3) != 0);
        s_face = $urandom_range(0, 1);
      end
      px = m_sx - 4 + $urandom_range(0, 135);
      py = m_sy - 4 + $urandom_range(0, 135);
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      if (py < 0) py = 0;
      if (py > 1023) py = 1023;
      drive(px, py, ($urandom_range(0, 4) != 0), tk);
    end

    // Asynchronous reset in the middle of a walking, hitting burst
    s_x = 100; s_y = 50; s_walk = 1'b1; s_face = 1'b0;
    for (int t = 0; t < 8; t++) drive(110 + t, 55, 1'b1, 1'b1);
    drive(130, 70, 1'b1, 1'b0);
    drive(130, 70, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    pix_valid = 1'b0; frame_tick = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    s_walk = 1'b0;
    s_x = 100; s_y = 50;
    drive(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(100 + 10 * i, 50 + 10 * i, 1'b1, 1'b0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/p1_sprite_fetch.md
P1_SPRITE_FETCH -- requirements
Module: p1_sprite_fetch

Interface
REQ-001 Parameters: SPRITE_W, 128, sprite width in pixels (fixed, power of two).
REQ-002 Parameters: SPRITE_H, 128, sprite height in pixels.
REQ-003 Parameters: NUM_FRAMES, 3, number of walking animation frames.
REQ-004 Parameters: TICKS_PER_STEP, 8, frame_tick pulses per animation step (1..255).
REQ-005 Parameters: TRANSPARENT, 12'hF0F, RGB 4:4:4 colour key treated as see-through.
REQ-006 Ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Ports: pix_x  in  10  current screen column; pix_y  in  10  current screen row; pix_valid  in  1  active video qualifier.
REQ-008 Ports: frame_tick  in  1  one-cycle pulse per video frame (vertical blank).
REQ-009 Ports: sprite_x  in  10  sprite left edge; sprite_y  in  10  sprite top edge; walking  in  1  animate when high; facing_left  in  1  mirror request.
REQ-010 Ports: rom_addr  out  14  sprite ROM address; frame_sel  out  2  ROM frame select; rom_data  in  12  ROM pixel, valid one cycle after rom_addr.
REQ-011 Ports: pixel_out  out  12  sprite colour; pixel_hit  out  1  opaque sprite pixel present; out_valid  out  1  pixel_out/pixel_hit qualifier.

Function
REQ-012 sprite_x, sprite_y, facing_left SHALL be latched only in the cycle frame_tick=1; all address math SHALL use the latched copies (no mid-frame tearing).
REQ-013 Hit test SHALL use 11-bit unsigned arithmetic: in_box = pix_valid & pix_x>=sx & pix_x<sx+SPRITE_W & pix_y>=sy & pix_y<sy+SPRITE_H; no wrap for sx+SPRITE_W>1023.
REQ-014 Stage 1 (cycle N+1): rom_addr SHALL register {dy[6:0], col[6:0]}, dy=pix_y-sy, col=pix_x-sx; in_box and pix_valid SHALL register alongside.
REQ-015 When in_box=0, rom_addr SHALL register 14'd0.
REQ-016 Stage 2 (cycle N+2): rom_data is consumed; the stage-1 flags SHALL be delayed one cycle to align.
REQ-017 Stage 3 (cycle N+3): pixel_out<=rom_data, pixel_hit<=in_box & (rom_data!=TRANSPARENT), out_valid<=pix_valid; total latency from pix_x/pix_y to outputs SHALL be exactly 3 cycles, fully pipelined, one pixel per clock.
REQ-018 When pixel_hit=0, pixel_out SHALL be 12'h000.
REQ-019 Animation state machine: states IDLE, WALK. IDLE->WALK on frame_tick & walking; WALK->IDLE on frame_tick & !walking.
REQ-020 In IDLE, frame_sel SHALL be 0 and the tick counter SHALL be 0.
REQ-021 In WALK, the tick counter SHALL increment on each frame_tick; when it reaches TICKS_PER_STEP-1 it SHALL clear and frame_sel SHALL advance, wrapping NUM_FRAMES-1 -> 0.
REQ-022 frame_sel SHALL change only in the cycle after a frame_tick, never during active video.
REQ-023 On the frame_tick that enters IDLE, frame_sel SHALL return to 0 on that same update.
REQ-024 frame_tick coinciding with pix_valid=1: the latch and the frame_sel update take effect; in-flight pipeline pixels are not flushed.

Reset
REQ-025 While rst_n=0: rom_addr=0, frame_sel=0, pixel_out=0, pixel_hit=0, out_valid=0, all pipeline flags 0, tick counter 0, state IDLE, latched position 0, latched facing 0.
REQ-026 Reset assertion mid-line SHALL clear the pipeline immediately (asynchronous); the first valid output after release SHALL be 3 cycles after the first pix_valid sampled high.

Configuration
REQ-027 Macro SPRITE_MIRROR_EN: when defined, col SHALL be (SPRITE_W-1)-(pix_x-sx) if latched facing_left=1, else pix_x-sx.
REQ-028 Without SPRITE_MIRROR_EN, facing_left SHALL be ignored and col SHALL always be pix_x-sx.

Verification
REQ-029 Latch sx=100, sy=50 via frame_tick; drive pix_x=100, pix_y=50, pix_valid=1 -> rom_addr=14'd0 at N+1; rom_data=12'hABC returned -> pixel_out=12'hABC, pixel_hit=1, out_valid=1 at N+3.
REQ-030 Same sprite, pix_x=227, pix_y=177 -> rom_addr=14'h3FFF; pix_x=228 -> rom_addr=0, pixel_hit=0, pixel_out=0.
REQ-031 rom_data=12'hF0F inside box -> pixel_hit=0, pixel_out=0, out_valid=1.
REQ-032 walking=1, 24 frame_tick pulses -> frame_sel sequence 0,1,2,0 advancing after ticks 8, 16, 24; drop walking, next tick -> frame_sel=0.
REQ-033 SPRITE_MIRROR_EN defined, facing_left=1 latched, sx=100, pix_x=100, pix_y=50 -> rom_addr=14'd127; undefined -> rom_addr=14'd0.
REQ-034 sx=1000, pix_x=1020 -> in_box=1 with col=20 (no 10-bit wrap); assert rst_n=0 mid-burst -> all outputs 0 within the same cycle.
